// File: rtl/trade_cmd_sequencer.sv
// trade_cmd_sequencer
// Parses ASCII command frames from a UART byte stream and hands decoded
// commands to the trading datapath.
//   "S:ddd.dd\n" -> threshold command (cmd_type=1)
//   "P:ddd.dd\n" -> price command     (cmd_type=0)
// The decoded value is in cents: integer part * 100 + two fraction digits.
// Optional build macro TRADE_CMD_TIMEOUT_EN: when defined, a frame that is
// idle mid-way for TIMEOUT_CYCLES cycles is aborted with err_code=3.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle byte strobe
//   cmd_valid  decoded command pending (valid/ready handshake)
//   cmd_ready  datapath accepts the pending command
//   cmd_type   0 = price, 1 = threshold
//   cmd_value  value in cents
//   err_pulse  one-cycle error strobe
//   err_code   1 syntax, 2 overrun, 3 timeout; held until the next error
//   busy       parser is inside a frame (state not IDLE)
module trade_cmd_sequencer #(
  parameter int VAL_W          = 17,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_type,
  output logic [VAL_W-1:0] cmd_value,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_CL = 8'h3A;
  localparam logic [7:0] CH_DT = 8'h2E;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {IDLE, COLON, INT, FRAC, EOL, DISCARD} state_t;

  state_t           state;
  logic             type_reg;
  logic [VAL_W-1:0] acc;
  logic [1:0]       int_cnt;
  logic             frac_cnt;
  logic             cr_seen;

  logic             is_digit;
  logic [VAL_W-1:0] acc_step;
  logic             handshake;
  state_t           err_state;

  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // For ASCII '0'..'9' the low nibble is the digit value.
  assign acc_step  = acc * VAL_W'(10) + VAL_W'(rx_data[3:0]);
  assign handshake = cmd_valid & cmd_ready;
  // An offending '\n' already ends the frame, so there is nothing to discard.
  assign err_state = (rx_data == CH_LF) ? IDLE : DISCARD;
  assign busy      = (state != IDLE);

`ifdef TRADE_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      type_reg  <= 1'b0;
      acc       <= '0;
      int_cnt   <= '0;
      frac_cnt  <= 1'b0;
      cr_seen   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_type  <= 1'b0;
      cmd_value <= '0;
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
`ifdef TRADE_CMD_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      // A completing frame below may re-assert cmd_valid in the same cycle.
      if (handshake) cmd_valid <= 1'b0;

      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == CH_S || rx_data == CH_P) begin
              type_reg <= (rx_data == CH_S);
              acc      <= '0;
              int_cnt  <= '0;
              frac_cnt <= 1'b0;
              cr_seen  <= 1'b0;
              state    <= COLON;
            end else if (rx_data != CH_CR && rx_data != CH_LF) begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= DISCARD;
            end
          end
          COLON: begin
            if (rx_data == CH_CL) begin
              state <= INT;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= err_state;
            end
          end
          INT: begin
            if (is_digit && int_cnt != 2'd3) begin
              acc     <= acc_step;
              int_cnt <= int_cnt + 2'd1;
            end else if (rx_data == CH_DT && int_cnt != 2'd0) begin
              state <= FRAC;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= err_state;
            end
          end
          FRAC: begin
            if (is_digit) begin
              acc      <= acc_step;
              frac_cnt <= 1'b1;
              if (frac_cnt) state <= EOL;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= err_state;
            end
          end
          EOL: begin
            if (rx_data == CH_LF) begin
              state <= IDLE;
              if (!cmd_valid || handshake) begin
                cmd_valid <= 1'b1;
                cmd_type  <= type_reg;
                cmd_value <= acc;
              end else begin
                // Pending command not yet taken: keep it, drop the new one.
                err_pulse <= 1'b1;
                err_code  <= 2'd2;
              end
            end else if (rx_data == CH_CR && !cr_seen) begin
              cr_seen <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'd1;
              state     <= DISCARD;
            end
          end
          DISCARD: begin
            if (rx_data == CH_LF) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

`ifdef TRADE_CMD_TIMEOUT_EN
      // Counts idle cycles inside a frame; any byte restarts the count.
      if (rx_valid || state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt    <= '0;
        state     <= IDLE;
        acc       <= '0;
        err_pulse <= 1'b1;
        err_code  <= 2'd3;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_trade_cmd_sequencer.sv
module tb_trade_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [16:0] cmd_value;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;

  int passed = 0;
  int total  = 0;

  // Monitor results, sampled 1 time unit before each rising edge.
  int          xfer_cnt = 0;
  int          err_cnt  = 0;
  logic [16:0] last_val = '0;
  logic        last_type = 1'b0;
  logic [1:0]  last_err = '0;

  int x0, e0;

  trade_cmd_sequencer #(.VAL_W(17), .TIMEOUT_CYCLES(20000)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_value(cmd_value), .err_pulse(err_pulse), .err_code(err_code),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        xfer_cnt++;
        last_val  = cmd_value;
        last_type = cmd_type;
        $display("xfer: type=%0d value=%0d", cmd_type, cmd_value);
      end
      if (err_pulse) begin
        err_cnt++;
        last_err = err_code;
        $display("error strobe: code=%0d", err_code);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b1;
    idle(3);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_type",  cmd_type, 0);
    check("rst_cmd_value", cmd_value, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code",  err_code, 0);
    check("rst_busy",      busy, 0);
    rst = 1'b0;
    idle(2);

    // Threshold frame, latency 1 after '\n'
    x0 = xfer_cnt; e0 = err_cnt;
    send_str("S:200.00");
    check("thr_busy", busy, 1);
    send_byte(8'h0A);
    check("thr_valid", cmd_valid, 1);
    check("thr_type",  cmd_type, 1);
    check("thr_value", cmd_value, 20000);
    idle(1);
    check("thr_valid_drop", cmd_valid, 0);
    idle(1);
    check("thr_xfers", xfer_cnt - x0, 1);
    check("thr_no_err", err_cnt - e0, 0);

    // Price frames, second with CR before LF
    send_str("P:123.45\n"); idle(2);
    check("p1_value", last_val, 12345);
    check("p1_type", last_type, 0);
    send_str("P:7.05\r\n"); idle(2);
    check("p2_value", last_val, 705);
    check("p2_type", last_type, 0);

    // Syntax: one fraction digit, error on '\n'
    x0 = xfer_cnt; e0 = err_cnt;
    send_str("P:1.5\n");
    check("syn1_pulse", err_pulse, 1);
    check("syn1_code", err_code, 1);
    idle(2);
    check("syn1_busy", busy, 0);
    check("syn1_no_cmd", xfer_cnt - x0, 0);

    // Bad leading byte: a single error, rest discarded
    e0 = err_cnt;
    send_str("X:9.99\n"); idle(2);
    check("syn2_errs", err_cnt - e0, 1);
    check("syn2_busy", busy, 0);

    // Fourth integer digit
    e0 = err_cnt;
    send_str("P:100");
    check("syn3_pre", err_pulse, 0);
    send_byte("0");
    check("syn3_pulse", err_pulse, 1);
    send_str(".00\n"); idle(2);
    check("syn3_errs", err_cnt - e0, 1);
    check("syn3_no_cmd", xfer_cnt - x0, 0);
    send_str("P:1.00\n"); idle(2);
    check("rec_value", last_val, 100);

    // Backpressure and overrun
    cmd_ready = 1'b0;
    x0 = xfer_cnt;
    send_str("S:050.00\n");
    idle(5);
    check("bp_valid", cmd_valid, 1);
    check("bp_value", cmd_value, 5000);
    send_str("P:001.00\n");
    check("ovr_pulse", err_pulse, 1);
    check("ovr_code", err_code, 2);
    check("ovr_value", cmd_value, 5000);
    check("ovr_type", cmd_type, 1);
    check("ovr_no_xfer", xfer_cnt - x0, 0);
    cmd_ready = 1'b1;
    idle(3);
    check("bp_xfers", xfer_cnt - x0, 1);
    check("bp_xfer_val", last_val, 5000);
    check("bp_valid_off", cmd_valid, 0);

    // Completion coinciding with the handshake replaces without error
    cmd_ready = 1'b0;
    x0 = xfer_cnt; e0 = err_cnt;
    send_str("S:1.00\n");
    send_str("P:2.00");
    cmd_ready = 1'b1;
    send_byte(8'h0A);
    check("rep_valid", cmd_valid, 1);
    check("rep_value", cmd_value, 200);
    check("rep_type",  cmd_type, 0);
    idle(2);
    check("rep_xfers", xfer_cnt - x0, 2);
    check("rep_last", last_val, 200);
    check("rep_no_err", err_cnt - e0, 0);

    // Mid-frame inactivity
    e0 = err_cnt;
    send_str("P:12");
`ifdef TRADE_CMD_TIMEOUT_EN
    idle(20001);
    check("to_errs", err_cnt - e0, 1);
    check("to_code", last_err, 3);
    check("to_busy", busy, 0);
    send_str("P:12.34\n"); idle(2);
`else
    idle(200);
    check("noto_busy", busy, 1);
    check("noto_errs", err_cnt - e0, 0);
    send_str(".34\n"); idle(2);
`endif
    check("after_idle_val", last_val, 1234);

    // Reset mid-frame drops the frame
    x0 = xfer_cnt;
    send_str("S:45");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mr_busy", busy, 0);
    send_byte(".");
    check("mr_pulse", err_pulse, 1);
    check("mr_code", err_code, 1);
    send_str("00\n"); idle(2);
    check("mr_no_cmd", xfer_cnt - x0, 0);
    send_str("S:45.00\n"); idle(2);
    check("mr_value", last_val, 4500);
    check("mr_type", last_type, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trade_cmd_sequencer.md
Name: trade_cmd_sequencer

Overview:
Sits between the UART byte receiver and the trading datapath (threshold register, price comparator, display). Parses ASCII frames "S:ddd.dd\n" (set threshold) and "P:ddd.dd\n" (price update) into binary cents. Issues each decoded command to the datapath through a valid/ready handshake. Reports syntax, overrun and timeout errors.

Parameters:
VAL_W, 17, width of cmd_value in cents (max 99999 fits).
TIMEOUT_CYCLES, 20000, idle cycles mid-frame before abort (used only with the optional feature).

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
cmd_valid  out  1  decoded command available
cmd_ready  in  1  datapath accepts command
cmd_type  out  1  0 = price (P), 1 = threshold (S)
cmd_value  out  VAL_W  value in cents
err_pulse  out  1  one-cycle error strobe
err_code  out  2  1 syntax, 2 overrun, 3 timeout; held until next error
busy  out  1  parser not in IDLE

Behaviour:
- Reset: state IDLE; cmd_valid=0, cmd_type=0, cmd_value=0, err_pulse=0, err_code=0, busy=0, accumulators and counters cleared. Reset mid-frame or mid-handshake drops the frame and any pending command.
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Bytes are consumed only on rx_valid. Every byte is processed in the cycle it arrives.
- FSM states: IDLE, COLON, INT, FRAC, EOL, DISCARD.
  - IDLE: 'S' or 'P' latches the type and goes to COLON. '\r' and '\n' are ignored. Any other byte is a syntax error and goes to DISCARD.
  - COLON: ':' goes to INT. Any other byte is a syntax error.
  - INT: a digit updates acc = acc*10 + d and increments int_cnt. '.' goes to FRAC only if int_cnt is 1..3. A 4th digit, '.' with int_cnt=0, or any other byte is a syntax error.
  - FRAC: exactly 2 digits are accumulated the same way. After the 2nd digit go to EOL. A non-digit is a syntax error.
  - EOL: '\r' is ignored once. '\n' completes the frame. Anything else is a syntax error.
  - DISCARD: drop bytes until '\n', then go to IDLE. The '\n' itself is not an error.
- Syntax error: err_pulse high for 1 cycle in the cycle after the offending byte; err_code=1; no command issued.
- Completion: cmd_valid rises in the cycle after the '\n' byte (latency 1) with cmd_type and cmd_value (= int*100 + frac).
- Handshake:
  - cmd_valid, cmd_type and cmd_value are held stable until the cycle where cmd_valid and cmd_ready are both high.
  - cmd_valid deasserts in the following cycle unless a new command completes in that same cycle.
  - cmd_ready is ignored while cmd_valid=0.
- Overrun: parsing continues while a command is pending. If another frame completes while cmd_valid=1 and that cycle is not the handshake cycle:
  - the new frame is dropped; the pending command is kept;
  - err_pulse fires with err_code=2.
  - If completion coincides with the handshake cycle, the new command replaces the pending one with no error.
- busy = (state != IDLE).
- Width: the accumulator is VAL_W bits. 999.99 gives 99999, so no overflow is reachable given the digit limits.

Optional Feature:
TRADE_CMD_TIMEOUT_EN
- Defined:
  - A counter clears on every rx_valid and counts while busy.
  - At TIMEOUT_CYCLES the FSM returns to IDLE (not DISCARD) and clears the accumulator; err_pulse fires with err_code=3.
  - The counter holds at 0 in IDLE.
- Undefined: no counter logic; the parser waits indefinitely mid-frame; err_code 3 never occurs.

Test Plan:
- Threshold: reset, cmd_ready=1, send "S:200.00\n" -> one cmd_valid cycle with cmd_type=1, cmd_value=20000, one cycle after '\n'; no err_pulse.
- Price: send "P:123.45\n" then "P:7.05\r\n" -> cmd_value=12345 then 705, both cmd_type=0.
- Syntax: send "P:1.5\n" -> err_pulse, err_code=1, no cmd_valid. Send "X:9.99\n" then "P:1000.00\n" -> first frame: a single err_pulse, then discarded. Second frame: err_pulse on the 4th integer digit, no command. Then "P:1.00\n" -> cmd_value=100.
- Handshake/overrun: cmd_ready=0, send "S:050.00\n" -> cmd_valid held, value 5000 stable. Send "P:001.00\n" -> err_code=2, value still 5000. Raise cmd_ready -> single transfer of 5000.
- Timeout (macro defined, TIMEOUT_CYCLES=20000): send "P:12" then idle 20001 cycles -> err_code=3, busy=0. Then "P:12.34\n" -> 1234.
- Reset mid-frame: send "S:45", assert rst 1 cycle, send ".00\n" -> syntax error on '.', no command. Then "S:45.00\n" -> 4500.
